// File: rtl/pwm_start_arbiter.sv
// pwm_start_arbiter: round-robin owner of one PWM generator, sequencing grant, start pulse, run/timeout and guard gap.
module pwm_start_arbiter #(
    parameter int N_REQ = 4,
    parameter int START_LEN = 8,
    parameter int GAP = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             pwm_done,
    output logic             pwm_start,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] ack,
    output logic             timeout_err,
    output logic             busy
);
    localparam int PW = $clog2(N_REQ);
    localparam int CMAX = (START_LEN > GAP) ? START_LEN : GAP;
    localparam int CW = $clog2(CMAX + 1);
    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_GAP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0] tcnt, tcnt_n;
    logic [PW-1:0] ptr, ptr_n, win, j;
    logic found, start_n, terr_n;
    logic [N_REQ-1:0] grant_n, ack_n;
    assign busy = state != S_IDLE;
    // ptr holds the last winner; the search starts one past it and wraps at N_REQ
    always_comb begin
        win = '0;
        found = 1'b0;
        j = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            j = (j == PW'(N_REQ - 1)) ? '0 : j + PW'(1);
            if (!found && req[j]) begin
                win = j;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            tcnt <= '0;
            ptr <= PW'(N_REQ - 1);
            pwm_start <= 1'b0;
            grant <= '0;
            ack <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            tcnt <= tcnt_n;
            ptr <= ptr_n;
            pwm_start <= start_n;
            grant <= grant_n;
            ack <= ack_n;
            timeout_err <= terr_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        tcnt_n = tcnt;
        ptr_n = ptr;
        start_n = pwm_start;
        grant_n = grant;
        ack_n = '0;
        terr_n = 1'b0;
        case (state)
            S_IDLE: if (found) begin
                grant_n = N_REQ'(1) << win;
                start_n = 1'b1;
                cnt_n = CW'(START_LEN - 1);
                ptr_n = win;
                state_n = S_START;
            end
            S_START: if (cnt == '0) begin
                start_n = 1'b0;
                tcnt_n = '0;
                state_n = S_RUN;
            end else cnt_n = cnt - CW'(1);
            // done takes priority over the expiry edge
            S_RUN: if (pwm_done) begin
                ack_n = grant;
                grant_n = '0;
                cnt_n = CW'(GAP - 1);
                state_n = S_GAP;
            end else if (tcnt == 8'(TIMEOUT - 1)) begin
                terr_n = 1'b1;
                grant_n = '0;
                cnt_n = CW'(GAP - 1);
                state_n = S_GAP;
            end else tcnt_n = tcnt + 8'd1;
            default: if (cnt == '0) state_n = S_IDLE;
                     else cnt_n = cnt - CW'(1);
        endcase
    end
endmodule

// File: tb/tb_pwm_start_arbiter.sv
// tb_pwm_start_arbiter: randomized burst-level checking of pwm_start_arbiter against a timing model.
module tb_pwm_start_arbiter;
    localparam int N = 4;
    localparam int SL = 8;
    localparam int GP = 4;
    localparam int TO = 255;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    logic pwm_done = 1'b0;
    logic pwm_start, timeout_err, busy;
    logic [N-1:0] grant, ack;
    int errors = 0;
    int checks = 0;
    int last = N - 1;

    pwm_start_arbiter #(.N_REQ(N), .START_LEN(SL), .GAP(GP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .pwm_done(pwm_done), .pwm_start(pwm_start),
        .grant(grant), .ack(ack), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] r, input int from);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (from + k) % N;
            if (r[c[1:0]]) return c;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        pwm_done = 1'b0;
        #1;
        checks++;
        if ({pwm_start, grant, ack, timeout_err, busy} !== '0)
            $display("FAIL reset got=%b exp=0", {pwm_start, grant, ack, timeout_err, busy});
        @(negedge clk);
        rst = 1'b0;
        last = N - 1;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if ({pwm_start, grant, ack, timeout_err, busy} !== '0) begin
                errors++;
                $display("FAIL idle got=%b exp=0", {pwm_start, grant, ack, timeout_err, busy});
            end
        end
    endtask

    // Entered at a falling edge while the arbiter should be idle; predicts every cycle of one burst.
    task automatic do_burst(input logic [N-1:0] r, input int done_at, input bit noise, input bit drop);
        int w, run, total;
        bit done;
        logic [N-1:0] oh;
        logic [2*N+2:0] exp_v, got;
        req = r;
        pwm_done = 1'b0;
        checks++;
        if ({pwm_start, grant, ack, timeout_err, busy} !== '0) begin
            errors++;
            $display("FAIL idle_entry got=%b exp=0", {pwm_start, grant, ack, timeout_err, busy});
        end
        w = rr_pick(r, last);
        last = w;
        oh = 4'b0001 << w;
        done = done_at > 0 && done_at <= TO;
        run = done ? done_at : TO;
        total = SL + run + GP;
        for (int t = 0; t < total; t++) begin
            @(negedge clk);
            got = {pwm_start, grant, ack, timeout_err, busy};
            exp_v = {t < SL, (t < SL + run) ? oh : {N{1'b0}}, (t == SL + run && done) ? oh : {N{1'b0}},
                     t == SL + run && !done, 1'b1};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL burst req=%b t=%0d got=%b exp=%b", r, t, got, exp_v);
            end
            pwm_done = (done && t == SL + run - 1) ||
                       (noise && (t < SL || t >= SL + run) && $urandom_range(0, 1) == 1);
            if (drop && t == 2) req = '0;
        end
        @(negedge clk);
        pwm_done = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        idle(2);
    endtask

    task automatic test_single();
        do_burst(4'b0001, 5, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic test_round_robin();
        apply_reset();
        repeat (5) do_burst(4'b1111, 2, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic test_timeout();
        do_burst(4'b0100, 0, 1'b0, 1'b0);
        do_burst(4'b0001, 3, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_done();
        repeat (4) do_burst(4'($urandom_range(1, 15)), 3, 1'b1, 1'b0);
    endtask

    task automatic test_drop_and_expiry();
        do_burst(4'b0010, 4, 1'b0, 1'b1);
        do_burst(4'b1000, TO, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        req = 4'b0100;
        repeat (SL + 3) @(negedge clk);
        checks++;
        if (grant !== 4'b0100 || !busy) begin
            errors++;
            $display("FAIL mid_run_owner got=%b exp=0100", grant);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pwm_start, grant, ack, timeout_err, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0", {pwm_start, grant, ack, timeout_err, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        last = N - 1;
        do_burst(4'b1111, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        repeat (25) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            do_burst(4'($urandom_range(1, 15)),
                     ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ignored_done();
        test_drop_and_expiry();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
